// File: rtl/ysyx_22050039_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle core sequencer: FSM states,
// decoder-class bit positions and trap cause codes.
package ysyx_22050039_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MULDIV = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  localparam int DEC_W       = 7;
  localparam int DEC_LOAD    = 0;
  localparam int DEC_STORE   = 1;
  localparam int DEC_MULDIV  = 2;
  localparam int DEC_WPC     = 3;
  localparam int DEC_WREG    = 4;
  localparam int DEC_EBREAK  = 5;
  localparam int DEC_INVALID = 6;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_FETCH_TO = 2'd1,
    CAUSE_EXEC_TO  = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } cause_e;

  // Only the decoder fields still needed after DECODE are kept.
  typedef struct packed {
    logic wreg;
    logic store;
  } dec_lat_t;

  function automatic logic dec_illegal(input logic [DEC_W-1:0] d);
    return d[DEC_INVALID]
         | (d[DEC_LOAD] & d[DEC_STORE])
         | (d[DEC_MULDIV] & (d[DEC_LOAD] | d[DEC_STORE]));
  endfunction

endpackage

// File: rtl/ysyx_22050039_watchdog.sv
// Handshake watchdog: counts waiting cycles and flags the cycle in which
// the TIMEOUT-th consecutive wait occurs.
module ysyx_22050039_watchdog #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + TO_W'(1);
  end

  assign hit_o = en_i & (cnt_q == LIMIT);

endmodule

// File: rtl/ysyx_22050039_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> (MULDIV | MEM) -> WB,
// with sticky halt/trap states and a handshake watchdog.
module ysyx_22050039_seq_ctrl
  import ysyx_22050039_seq_ctrl_pkg::*;
#(
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             inst_le,
  input  logic [DEC_W-1:0] dec_info,
  output logic             md_start,
  input  logic             md_done,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             reg_wen,
  output logic             pc_wen,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_dbg
);

  state_e           state_q, state_d;
  dec_lat_t         dec_q, dec_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             md_first_q, md_first_d;
  logic             wait_st, awaited, wd_hit;
  logic             unused_wpc;

  // The PC target select is consumed directly by the datapath.
  assign unused_wpc = dec_info[DEC_WPC];

  assign wait_st = (state_q == ST_FETCH) | (state_q == ST_MULDIV) | (state_q == ST_MEM);

  always_comb begin
    awaited = 1'b0;
    case (state_q)
      ST_FETCH:  awaited = imem_ready;
      ST_MULDIV: awaited = md_done;
      ST_MEM:    awaited = dmem_ready;
      default:   awaited = 1'b0;
    endcase
  end

  // Held clear outside the waiting states, so every entry starts from zero.
  ysyx_22050039_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_n_i (rst),
    .clr_i   (~wait_st),
    .en_i    (wait_st & ~awaited),
    .hit_o   (wd_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      dec_q      <= '0;
      cause_q    <= CAUSE_NONE;
      instret_q  <= '0;
      md_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_q      <= dec_d;
      cause_q    <= cause_d;
      instret_q  <= instret_d;
      md_first_q <= md_first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    md_first_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (wd_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TO;
        end
      end
      ST_DECODE: begin
        dec_d.wreg  = dec_info[DEC_WREG];
        dec_d.store = dec_info[DEC_STORE];
        if (dec_illegal(dec_info)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_info[DEC_EBREAK]) begin
          state_d = ST_HALT;
        end else if (dec_info[DEC_MULDIV]) begin
          state_d    = ST_MULDIV;
          md_first_d = 1'b1;
        end else if (dec_info[DEC_LOAD] | dec_info[DEC_STORE]) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MULDIV, ST_MEM: begin
        if (awaited) begin
          state_d = ST_WB;
        end else if (wd_hit) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_EXEC_TO;
        end
      end
      ST_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
    endcase
  end

  assign imem_req   = (state_q == ST_FETCH);
  assign inst_le    = (state_q == ST_FETCH) & imem_ready;
  assign md_start   = (state_q == ST_MULDIV) & md_first_q;
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = (state_q == ST_MEM) & dec_q.store;
  assign reg_wen    = (state_q == ST_WB) & dec_q.wreg;
  assign pc_wen     = (state_q == ST_WB);
  assign halted     = (state_q == ST_HALT) | (state_q == ST_TRAP);
  assign trap       = (state_q == ST_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state_dbg  = state_q;

endmodule
